// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register of the 16-bit core.
//
// Registers the decoded instruction and presents the ALU operands, opcode and
// control signals to EX. Each source operand is resolved through a forwarding
// mux that checks EX, then MEM, then WB. Operand B is either the immediate or
// the forwarded rs2. A load in EX whose destination a decoding instruction
// needs raises a one-cycle stall and loads a bubble. A taken-branch flush
// squashes the incoming instruction and overrides the stall.
//
// Ports:
//   clk, rst                     clock (rising edge); synchronous active-high reset
//   id_valid, id_op              decode valid, ALU opcode
//   id_rs1/rs2/rd                register indices (r0 is hardwired zero)
//   id_rs1_val/rs2_val, id_imm   register-file read data, sign-extended immediate
//   id_use_imm                   operand B takes the immediate
//   id_reg_write/mem_read/mem_write  control
//   flush                        squash the incoming instruction
//   ex_result                    live ALU result of the instruction in EX
//   mem_we/rd/data, wb_we/rd/data  later-stage writeback candidates
//   stall                        combinational hold request to fetch/decode
//   ex_*                         registered EX-stage outputs

// One source-operand forwarding mux. Priority is EX > MEM > WB > register file.
// r0 never forwards, so a write that targets r0 cannot leak into an operand.
module id_ex_fwd #(
  parameter int WIDTH = 16,
  parameter int RBITS = 3
) (
  input  logic [RBITS-1:0] src,
  input  logic [WIDTH-1:0] reg_val,
  input  logic             ex_en,
  input  logic [RBITS-1:0] ex_rd,
  input  logic [WIDTH-1:0] ex_result,
  input  logic             mem_we,
  input  logic [RBITS-1:0] mem_rd,
  input  logic [WIDTH-1:0] mem_data,
  input  logic             wb_we,
  input  logic [RBITS-1:0] wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic [WIDTH-1:0] val
);
  logic nz;
  assign nz = (src != '0);

  always_comb begin
    val = reg_val;
    if (nz && ex_en && ex_rd == src)        val = ex_result;
    else if (nz && mem_we && mem_rd == src) val = mem_data;
    else if (nz && wb_we && wb_rd == src)   val = wb_data;
  end
endmodule

module id_ex_stage #(
  parameter int WIDTH = 16,
  parameter int RBITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_op,
  input  logic [RBITS-1:0] id_rs1,
  input  logic [RBITS-1:0] id_rs2,
  input  logic [RBITS-1:0] id_rd,
  input  logic [WIDTH-1:0] id_rs1_val,
  input  logic [WIDTH-1:0] id_rs2_val,
  input  logic [WIDTH-1:0] id_imm,
  input  logic             id_use_imm,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             flush,
  input  logic [WIDTH-1:0] ex_result,
  input  logic             mem_we,
  input  logic [RBITS-1:0] mem_rd,
  input  logic [WIDTH-1:0] mem_data,
  input  logic             wb_we,
  input  logic [RBITS-1:0] wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic             stall,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic [3:0]       ex_op,
  output logic [WIDTH-1:0] ex_a,
  output logic [WIDTH-1:0] ex_b,
  output logic [WIDTH-1:0] ex_st_data,
  output logic [RBITS-1:0] ex_rd
);
  localparam int NUM_SRC = 2;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] st_data;
    logic [RBITS-1:0] rd;
  } ex_req_t;

  ex_req_t ex_q, ex_d;

  logic [NUM_SRC-1:0][RBITS-1:0] src;
  logic [NUM_SRC-1:0][WIDTH-1:0] reg_val;
  logic [NUM_SRC-1:0][WIDTH-1:0] fwd_val;

  assign src     = {id_rs2, id_rs1};
  assign reg_val = {id_rs2_val, id_rs1_val};

  // A load in EX has no result yet; its consumers stall instead of forwarding.
  logic ex_fwd_en;
  assign ex_fwd_en = ex_q.valid && ex_q.reg_write && !ex_q.mem_read;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_fwd
    id_ex_fwd #(.WIDTH(WIDTH), .RBITS(RBITS)) u_fwd (
      .src       (src[s]),
      .reg_val   (reg_val[s]),
      .ex_en     (ex_fwd_en),
      .ex_rd     (ex_q.rd),
      .ex_result (ex_result),
      .mem_we    (mem_we),
      .mem_rd    (mem_rd),
      .mem_data  (mem_data),
      .wb_we     (wb_we),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .val       (fwd_val[s])
    );
  end

  // Load-use hazard. The rs2 comparison is skipped for immediate ALU ops, but
  // a store still reads rs2 as store data even when operand B is the offset.
  logic hazard, rs1_hit, rs2_hit;
  assign rs1_hit = (ex_q.rd == id_rs1);
  assign rs2_hit = (ex_q.rd == id_rs2) && (!id_use_imm || id_mem_write);
  assign hazard  = id_valid && ex_q.valid && ex_q.mem_read &&
                   (ex_q.rd != '0) && (rs1_hit || rs2_hit);

  // Flush wins over the hazard; the squashed instruction need not wait.
  assign stall = hazard && !flush;

  always_comb begin
    ex_d           = '0;
    ex_d.valid     = 1'b1;
    ex_d.reg_write = id_reg_write;
    ex_d.mem_read  = id_mem_read;
    ex_d.mem_write = id_mem_write;
    ex_d.op        = id_op;
    ex_d.a         = fwd_val[0];
    ex_d.b         = id_use_imm ? id_imm : fwd_val[1];
    ex_d.st_data   = fwd_val[1];
    ex_d.rd        = id_rd;
  end

  // Reset, flush, hazard and empty decode all load the same all-zero bubble.
  // Because the bubble clears ex_valid, a stall lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush || hazard || !id_valid) ex_q <= '0;
    else                                     ex_q <= ex_d;
  end

  assign ex_valid     = ex_q.valid;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_op        = ex_q.op;
  assign ex_a         = ex_q.a;
  assign ex_b         = ex_q.b;
  assign ex_st_data   = ex_q.st_data;
  assign ex_rd        = ex_q.rd;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: each driven cycle pushes the reference
// model's next EX register contents; they are popped and compared after the edge.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_op;
  logic [2:0]  id_rs1, id_rs2, id_rd;
  logic [15:0] id_rs1_val, id_rs2_val, id_imm;
  logic        id_use_imm, id_reg_write, id_mem_read, id_mem_write;
  logic        flush;
  logic [15:0] ex_result;
  logic        mem_we;
  logic [2:0]  mem_rd;
  logic [15:0] mem_data;
  logic        wb_we;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        stall;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [3:0]  ex_op;
  logic [15:0] ex_a, ex_b, ex_st_data;
  logic [2:0]  ex_rd;

  always #5 clk = ~clk;

  id_ex_stage #(.WIDTH(16), .RBITS(3)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .flush(flush),
    .ex_result(ex_result), .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b),
    .ex_st_data(ex_st_data), .ex_rd(ex_rd)
  );

  typedef struct packed {
    logic v, rw, mr, mw;
    logic [3:0]  op;
    logic [15:0] a, b, st;
    logic [2:0]  rd;
  } ex_t;

  ex_t cur = '0;  // model's view of the EX register
  ex_t sb[$];
  int  n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] fwd(input logic [2:0] s, input logic [15:0] rv);
    if (s == 3'd0) return rv;
    if (cur.v && cur.rw && !cur.mr && cur.rd == s) return ex_result;
    if (mem_we && mem_rd == s) return mem_data;
    if (wb_we && wb_rd == s) return wb_data;
    return rv;
  endfunction

  // Inputs are already driven; predict, check stall, clock, check outputs.
  task automatic cycle(input string tag);
    ex_t nx, got;
    logic hz;
    hz = id_valid && cur.v && cur.mr && cur.rd != 3'd0 &&
         (cur.rd == id_rs1 || (cur.rd == id_rs2 && (!id_use_imm || id_mem_write)));
    nx = '0;
    if (!(rst || flush || hz || !id_valid)) begin
      nx.v = 1'b1; nx.rw = id_reg_write; nx.mr = id_mem_read; nx.mw = id_mem_write;
      nx.op = id_op; nx.rd = id_rd;
      nx.a  = fwd(id_rs1, id_rs1_val);
      nx.st = fwd(id_rs2, id_rs2_val);
      nx.b  = id_use_imm ? id_imm : nx.st;
    end
    sb.push_back(nx);
    #1;
    chk({tag, ".stall"}, 32'(stall), 32'(hz && !flush));
    @(posedge clk); #1;
    got = sb.pop_front();
    chk({tag, ".valid"}, 32'(ex_valid), 32'(got.v));
    chk({tag, ".ctl"}, 32'({ex_reg_write, ex_mem_read, ex_mem_write}), 32'({got.rw, got.mr, got.mw}));
    chk({tag, ".op"}, 32'(ex_op), 32'(got.op));
    chk({tag, ".a"}, 32'(ex_a), 32'(got.a));
    chk({tag, ".b"}, 32'(ex_b), 32'(got.b));
    chk({tag, ".st"}, 32'(ex_st_data), 32'(got.st));
    chk({tag, ".rd"}, 32'(ex_rd), 32'(got.rd));
    cur = got;
  endtask

  task automatic idle();
    rst = 0; id_valid = 0; id_op = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_val = 0; id_rs2_val = 0; id_imm = 0; id_use_imm = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; flush = 0;
    ex_result = 0; mem_we = 0; mem_rd = 0; mem_data = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic alu(input logic [2:0] rd, input logic [2:0] rs1, input logic [15:0] v1);
    idle(); id_valid = 1; id_op = 4'd1; id_rd = rd; id_reg_write = 1;
    id_rs1 = rs1; id_rs1_val = v1; id_use_imm = 1; id_imm = 16'h0001;
  endtask

  task automatic load(input logic [2:0] rd);
    idle(); id_valid = 1; id_op = 4'd0; id_rd = rd; id_reg_write = 1;
    id_mem_read = 1; id_use_imm = 1; id_imm = 16'h0010;
  endtask

  initial begin
    idle(); rst = 1; id_valid = 1; id_rd = 3'd4; id_reg_write = 1; id_rs1_val = 16'hFFFF;
    @(posedge clk); #1;
    cycle("rst0");
    cycle("rst1");
    chk("rst.hard_zero", 32'({ex_valid, ex_op, ex_a, ex_rd}), 32'd0);

    // plain issue: 3 + imm 5
    idle(); id_valid = 1; id_op = 4'd0; id_rs1 = 3'd1; id_rs1_val = 16'h0003;
    id_use_imm = 1; id_imm = 16'h0005; id_rd = 3'd1; id_reg_write = 1;
    cycle("plain");
    chk("plain.abs", 32'({ex_a, ex_b}), 32'h0003_0005);

    // EX forwarding, then EX beats MEM
    alu(3'd2, 3'd0, 16'h0);                          cycle("exfwd.prod");
    alu(3'd2, 3'd2, 16'h0); ex_result = 16'h1234;    cycle("exfwd");
    chk("exfwd.abs", 32'(ex_a), 32'h1234);
    alu(3'd6, 3'd2, 16'h0); ex_result = 16'h1234;
    mem_we = 1; mem_rd = 3'd2; mem_data = 16'hBEEF;  cycle("expri");
    chk("expri.abs", 32'(ex_a), 32'h1234);

    // r0 never forwards
    alu(3'd0, 3'd0, 16'h0);                          cycle("r0.prod");
    alu(3'd1, 3'd0, 16'h0); ex_result = 16'h9999;
    mem_we = 1; mem_rd = 3'd0; mem_data = 16'h8888;
    wb_we = 1; wb_rd = 3'd0; wb_data = 16'h7777;     cycle("r0");
    chk("r0.abs", 32'(ex_a), 32'h0);

    // load-use on rs2: one stall, bubble, then MEM supplies the data
    load(3'd3);                                      cycle("lu.load");
    idle(); id_valid = 1; id_op = 4'd2; id_rs2 = 3'd3; id_rd = 3'd4; id_reg_write = 1;
    cycle("lu.stall");
    mem_we = 1; mem_rd = 3'd3; mem_data = 16'h00AA;  cycle("lu.resume");
    chk("lu.abs", 32'(ex_b), 32'h00AA);

    // flush during hazard
    load(3'd3);                                      cycle("fl.load");
    idle(); id_valid = 1; id_rs1 = 3'd3; id_rd = 3'd4; id_reg_write = 1; flush = 1;
    cycle("fl.flush");

    // WB forwarding into store data with immediate offset
    idle(); id_valid = 1; id_op = 4'd0; id_rs2 = 3'd5; id_use_imm = 1; id_imm = 16'h0004;
    id_mem_write = 1; wb_we = 1; wb_rd = 3'd5; wb_data = 16'h7777;
    cycle("store");
    chk("store.abs", 32'({ex_b, ex_st_data}), 32'h0004_7777);

    // immediate ALU op skips rs2 check; a store does not
    load(3'd5);                                      cycle("imm.load");
    alu(3'd6, 3'd1, 16'h0042); id_rs2 = 3'd5;        cycle("imm.nostall");
    load(3'd5);                                      cycle("st.load");
    idle(); id_valid = 1; id_rs2 = 3'd5; id_use_imm = 1; id_mem_write = 1;
    cycle("st.stall");

    // reset in the middle of a stall
    load(3'd3);                                      cycle("rs.load");
    idle(); id_valid = 1; id_rs1 = 3'd3; id_rd = 3'd2; id_reg_write = 1; rst = 1;
    cycle("rs.rst");
    rst = 0;                                         cycle("rs.after");

    // random traffic
    for (int i = 0; i < 60; i++) begin
      idle();
      id_valid = ($urandom_range(0, 7) != 0);
      id_op = 4'($urandom); id_rs1 = 3'($urandom); id_rs2 = 3'($urandom); id_rd = 3'($urandom);
      id_rs1_val = 16'($urandom); id_rs2_val = 16'($urandom); id_imm = 16'($urandom);
      id_use_imm = 1'($urandom); id_reg_write = 1'($urandom);
      id_mem_read = ($urandom_range(0, 3) == 0); id_mem_write = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0); ex_result = 16'($urandom);
      mem_we = 1'($urandom); mem_rd = 3'($urandom); mem_data = 16'($urandom);
      wb_we = 1'($urandom); wb_rd = 3'($urandom); wb_data = 16'($urandom);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 16-bit core: registers the decoded instruction and presents ALU operands, opcode and control to the execute stage. It resolves operand sources through forwarding from EX, MEM and WB, selects immediate vs register for operand B, and detects load-use hazards, stalling decode and inserting one bubble. Branch-taken flush squashes the incoming instruction.

## Interface
- WIDTH, 16, datapath width
- RBITS, 3, register index width; r0 reads as zero and is never forwarded

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  decode holds a valid instruction
- id_op  in  4  ALU opcode from decode
- id_rs1, id_rs2, id_rd  in  RBITS  source/dest indices
- id_rs1_val, id_rs2_val  in  WIDTH  register-file read data
- id_imm  in  WIDTH  sign-extended immediate
- id_use_imm  in  1  operand B = id_imm
- id_reg_write, id_mem_read, id_mem_write  in  1  control
- flush  in  1  squash incoming instruction (branch taken)
- ex_result  in  WIDTH  live ALU output for the instruction currently in EX
- mem_we  in  1, mem_rd  in  RBITS, mem_data  in  WIDTH  MEM-stage writeback candidate (load data already muxed in)
- wb_we  in  1, wb_rd  in  RBITS, wb_data  in  WIDTH  WB-stage write
- stall  out  1  combinational; decode/fetch hold
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered
- ex_op  out  4  registered
- ex_a, ex_b, ex_st_data  out  WIDTH  registered operands / store data
- ex_rd  out  RBITS  registered

## Operation
- Forwarding, per source s in {rs1, rs2}, combinational on ID-side inputs, priority high to low:
  1. EX: ex_valid & ex_reg_write & !ex_mem_read & ex_rd==s & s!=0 -> ex_result
  2. MEM: mem_we & mem_rd==s & s!=0 -> mem_data
  3. WB: wb_we & wb_rd==s & s!=0 -> wb_data
  4. else id_rsX_val
- ex_a = fwd(rs1); ex_b = id_use_imm ? id_imm : fwd(rs2); ex_st_data = fwd(rs2) always.
- Hazard = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | (ex_rd==id_rs2 & (!id_use_imm | id_mem_write))).
- stall = hazard & !flush.
- Register update each edge, priority: rst > flush > hazard > load.
  - rst, flush, hazard, or !id_valid: bubble, i.e. ex_valid, ex_reg_write, ex_mem_read, ex_mem_write = 0; ex_op = 0; ex_a, ex_b, ex_st_data = 0; ex_rd = 0.
  - load: all ex_* take the ID-side values, with ex_valid = 1.
- A stall lasts exactly one cycle per load. On the next cycle the load is in MEM, and its data arrives through mem_data.
- No internal state beyond the output register. No FSM beyond valid/bubble.

## Timing
- Latency 1: ID inputs at edge N appear on ex_* after edge N.
- stall is valid in the same cycle as the hazard. Upstream holds its id_* inputs stable while stall=1.
- Reset: every output register is 0 (ex_valid=0, ex_op=0, all data 0). stall is 0 while ex_valid=0.
- Reset asserted mid-stall: the bubble is loaded and the stall drops in the next cycle.
- Flush and hazard in the same cycle: the bubble is loaded and stall=0.
- EX and MEM both matching the same source: EX wins. rd=0 matches never forward.
- Operand-B hazard check is skipped for immediate ALU ops, but kept for stores, which need rs2 as store data.

## Test plan
- Reset: hold rst 2 cycles with id_valid=1 -> all ex_* = 0, stall = 0.
- Plain issue: id_op=4'd0, rs1_val=16'h0003, use_imm=1, imm=16'h0005 -> next cycle ex_a=3, ex_b=5, ex_op=0, ex_valid=1.
- EX forwarding: prior instruction ex_rd=2 with ex_reg_write=1, ex_result=16'h1234; then id_rs1=2, rs1_val=16'h0000 -> ex_a=16'h1234.
  - Same case with mem_rd=2, mem_data=16'hBEEF -> still 16'h1234.
  - With ex_rd=0 and rs1=0 -> ex_a=0.
- Load-use: load r3 in EX (ex_mem_read=1), id_rs2=3, use_imm=0 -> stall=1 for one cycle and a bubble enters EX.
  - Next cycle: mem_we=1, mem_rd=3, mem_data=16'h00AA -> ex_b=16'h00AA, stall=0.
- Flush with hazard: the load-use case plus flush=1 -> stall=0 and ex_valid=0 next cycle.
- WB forwarding and store data: wb_we=1, wb_rd=5, wb_data=16'h7777; store with rs2=5, use_imm=1, imm=4 -> ex_b=4, ex_st_data=16'h7777, ex_mem_write=1.
